// File: rtl/dmem_port_b_dma_if.sv
// Bundle of the DMA engine's command, stream, status and memory port-B signals.
// The slave modport is the engine's view; master is the host/memory environment.
interface dmem_port_b_dma_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SIZE    = 256,
  parameter int unsigned NUM_COL = 4
);
  localparam int unsigned LOGSIZE = $clog2(SIZE);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [LOGSIZE+1:0]   cmd_byte_addr;
  logic [LOGSIZE:0]     cmd_len;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [WIDTH-1:0]     wr_data;
  logic [NUM_COL-1:0]   wr_strb;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_last;

  logic                 busy;
  logic                 done;

  logic [WIDTH-1:0]     dmem_data_in;
  logic [WIDTH-1:0]     dmem_data_out;
  logic [LOGSIZE+1:0]   dmem_byte_addr;
  logic [NUM_COL-1:0]   dmem_byte_wr_en;

  modport slave (
    input  cmd_valid, cmd_write, cmd_byte_addr, cmd_len,
    input  wr_valid, wr_data, wr_strb,
    input  rd_ready,
    input  dmem_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done,
    output dmem_data_in, dmem_byte_addr, dmem_byte_wr_en
  );

  modport master (
    output cmd_valid, cmd_write, cmd_byte_addr, cmd_len,
    output wr_valid, wr_data, wr_strb,
    output rd_ready,
    output dmem_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done,
    input  dmem_data_in, dmem_byte_addr, dmem_byte_wr_en
  );
endinterface

// File: rtl/dmem_port_b_dma.sv
// Burst copy engine owning data-memory port B: streams words into memory or reads
// them out through a 4-entry FIFO with valid/ready backpressure.
module dmem_port_b_dma #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SIZE    = 256,
  parameter int unsigned NUM_COL = 4
) (
  input logic               clk,
  input logic               reset_n,
  dmem_port_b_dma_if.slave  bus
);
  localparam int unsigned LOGSIZE = $clog2(SIZE);
  localparam logic [LOGSIZE-1:0] LastWord = LOGSIZE'(SIZE - 1);
  localparam logic [LOGSIZE:0]   RemOne   = 'd1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [LOGSIZE-1:0]   r_addr;
  logic [LOGSIZE:0]     r_remaining;

  logic                 r_wr_pend;
  logic [LOGSIZE-1:0]   r_wr_addr;
  logic [WIDTH-1:0]     r_wr_data;
  logic [NUM_COL-1:0]   r_wr_strb;

  // One read in flight between address issue and capture of dmem_data_out.
  logic                 r_cap_valid;
  logic                 r_cap_last;

  logic [WIDTH-1:0]     r_fifo_data [4];
  logic [3:0]           r_fifo_last;
  logic [1:0]           r_rptr, r_wptr;
  logic [2:0]           r_count;

  logic                 w_cmd_hs, w_wr_ready, w_wr_hs, w_issue, w_push, w_pop, w_rd_valid;
  logic [LOGSIZE-1:0]   w_addr_inc;
  logic                 w_unused;

  assign w_unused   = ^bus.cmd_byte_addr[1:0];
  assign w_cmd_hs   = (r_state == StIdle) && bus.cmd_valid;
  assign w_wr_ready = (r_state == StWrite) && (r_remaining != '0);
  assign w_wr_hs    = w_wr_ready && bus.wr_valid;
  assign w_issue    = (r_state == StRead) && (r_remaining != '0) &&
                      ((r_count + {2'b00, r_cap_valid}) < 3'd4);
  assign w_push     = r_cap_valid;
  assign w_rd_valid = (r_count != 3'd0);
  assign w_pop      = w_rd_valid && bus.rd_ready;
  assign w_addr_inc = (r_addr == LastWord) ? '0 : r_addr + 1'b1;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0)  w_state_d = StDone;
          else if (bus.cmd_write) w_state_d = StWrite;
          else                    w_state_d = StRead;
        end
      end
      // Remaining hits zero on the last handshake; that write is driven this cycle.
      StWrite: if (r_remaining == '0) w_state_d = StDone;
      StRead:  if (w_pop && r_fifo_last[r_rptr]) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wr_pend   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_strb   <= '0;
      r_cap_valid <= 1'b0;
      r_cap_last  <= 1'b0;
      for (int i = 0; i < 4; i++) r_fifo_data[i] <= '0;
      r_fifo_last <= '0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_cmd_hs) begin
        r_addr      <= bus.cmd_byte_addr[LOGSIZE+1:2];
        r_remaining <= bus.cmd_len;
      end else if (w_wr_hs || w_issue) begin
        r_addr      <= w_addr_inc;
        r_remaining <= r_remaining - 1'b1;
      end

      r_wr_pend <= w_wr_hs;
      if (w_wr_hs) begin
        r_wr_addr <= r_addr;
        r_wr_data <= bus.wr_data;
        r_wr_strb <= bus.wr_strb;
      end

      r_cap_valid <= w_issue;
      r_cap_last  <= w_issue && (r_remaining == RemOne);

      if (w_push) begin
        r_fifo_data[r_wptr] <= bus.dmem_data_out;
        r_fifo_last[r_wptr] <= r_cap_last;
        r_wptr              <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  assign bus.cmd_ready       = (r_state == StIdle);
  assign bus.busy            = (r_state != StIdle);
  assign bus.done            = (r_state == StDone);
  assign bus.wr_ready        = w_wr_ready;
  assign bus.rd_valid        = w_rd_valid;
  assign bus.rd_data         = r_fifo_data[r_rptr];
  assign bus.rd_last         = w_rd_valid && r_fifo_last[r_rptr];
  assign bus.dmem_data_in    = r_wr_data;
  assign bus.dmem_byte_addr  = {(r_wr_pend ? r_wr_addr : r_addr), 2'b00};
  assign bus.dmem_byte_wr_en = r_wr_pend ? r_wr_strb : '0;
endmodule

// File: tb/tb_dmem_port_b_dma.sv
// Randomized bench for dmem_port_b_dma: a behavioural memory sits on port B and a
// word-level reference array predicts every write and every streamed read word.
module tb_dmem_port_b_dma;
  localparam int unsigned Width  = 32;
  localparam int unsigned Size   = 256;
  localparam int unsigned NumCol = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_port_b_dma_if #(.WIDTH(Width), .SIZE(Size), .NUM_COL(NumCol)) bus ();

  dmem_port_b_dma #(.WIDTH(Width), .SIZE(Size), .NUM_COL(NumCol)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem     [Size];
  logic [31:0] ref_mem [Size];
  logic [45:0] exp_wq  [$];
  logic [45:0] mon_e;
  int cyc = 0, n_cmp = 0, n_err = 0, n_done = 0;

  // Port-B memory: byte-lane writes, registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int b = 0; b < 4; b++)
      if (bus.dmem_byte_wr_en[b])
        mem[bus.dmem_byte_addr[9:2]][b*8 +: 8] <= bus.dmem_data_in[b*8 +: 8];
    bus.dmem_data_out <= mem[bus.dmem_byte_addr[9:2]];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.dmem_byte_wr_en != 4'h0) begin
      check_eq("wr_expected", exp_wq.size() != 0, 1);
      if (exp_wq.size() != 0) begin
        mon_e = exp_wq.pop_front();
        check_eq("wr_addr", bus.dmem_byte_addr, mon_e[45:36]);
        check_eq("wr_data", bus.dmem_data_in, mon_e[35:4]);
        check_eq("wr_strb", bus.dmem_byte_wr_en, mon_e[3:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_wr_ready", bus.wr_ready, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_rd_last", bus.rd_last, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);
    check_eq("rst_wr_en", bus.dmem_byte_wr_en, 0);
    check_eq("rst_addr", bus.dmem_byte_addr, 0);
    check_eq("rst_data_in", bus.dmem_data_in, 0);
  endtask

  task automatic send_cmd(input bit wr, input logic [9:0] ba, input int len, output int t);
    check_eq("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid     = 1'b1;
    bus.cmd_write     = wr;
    bus.cmd_byte_addr = ba;
    bus.cmd_len       = 9'(len);
    t = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("busy_after_cmd", bus.busy, 1);
  endtask

  // Garbage command offered while busy; the engine must ignore it.
  task automatic noise_cmd();
    bus.cmd_valid     = ($urandom_range(0, 3) == 0);
    bus.cmd_write     = 1'($urandom_range(0, 1));
    bus.cmd_byte_addr = 10'($urandom_range(0, 1023));
    bus.cmd_len       = 9'($urandom_range(0, 256));
  endtask

  task automatic finish_pulse();
    bus.cmd_valid = 1'b0;
    tick();
    check_eq("done_one_cycle", bus.done, 0);
    check_eq("idle_after_done", bus.cmd_ready, 1);
  endtask

  task automatic run_write(input logic [9:0] ba, input int len, input bit steady,
                           input logic [31:0] base, input bit rnd_data,
                           input logic [3:0] strb, input bit rnd_strb);
    int t, j, guard;
    logic [7:0] idx;
    logic [31:0] d;
    logic [3:0] s;
    send_cmd(1'b1, ba, len, t);
    j = 0;
    guard = 0;
    d = rnd_data ? $urandom : base;
    s = rnd_strb ? 4'($urandom_range(1, 15)) : strb;
    while (!bus.done && guard < 4 * len + 40) begin
      noise_cmd();
      bus.wr_valid = (j < len) && (steady || $urandom_range(0, 2) != 0);
      bus.wr_data  = bus.wr_valid ? d : $urandom;
      bus.wr_strb  = s;
      if (bus.wr_valid && bus.wr_ready) begin
        idx = ba[9:2] + 8'(j);
        exp_wq.push_back({idx, 2'b00, d, s});
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        j++;
        d = rnd_data ? $urandom : base + 32'(j);
        s = rnd_strb ? 4'($urandom_range(1, 15)) : strb;
      end
      tick();
      guard++;
    end
    bus.wr_valid = 1'b0;
    check_eq("wr_done_seen", bus.done, 1);
    check_eq("wr_words", j, len);
    if (steady) check_eq("wr_done_cycle", cyc, t + 2 + len);
    finish_pulse();
  endtask

  task automatic run_read(input logic [9:0] ba, input int len, input int mode);
    int t, j, guard, first;
    logic [7:0] idx;
    send_cmd(1'b0, ba, len, t);
    j = 0;
    guard = 0;
    first = -1;
    while (!bus.done && guard < 8 * len + 40) begin
      noise_cmd();
      if (mode == 0)      bus.rd_ready = 1'b1;
      else if (mode == 2) bus.rd_ready = !(cyc >= t + 3 && cyc <= t + 10);
      else                bus.rd_ready = 1'($urandom_range(0, 1));
      if (bus.rd_valid && first < 0) first = cyc;
      if (bus.rd_valid && bus.rd_ready) begin
        check_eq("rd_in_range", j < len, 1);
        if (j < len) begin
          idx = ba[9:2] + 8'(j);
          check_eq("rd_data", bus.rd_data, ref_mem[idx]);
          check_eq("rd_last", bus.rd_last, j == len - 1);
        end
        j++;
      end
      tick();
      guard++;
    end
    bus.rd_ready = 1'b0;
    check_eq("rd_done_seen", bus.done, 1);
    check_eq("rd_words", j, len);
    check_eq("rd_valid_at_done", bus.rd_valid, 0);
    check_eq("rd_first_cycle", first, t + 3);
    if (mode == 0) check_eq("rd_done_cycle", cyc, t + 3 + len);
    finish_pulse();
  endtask

  task automatic run_len0(input bit wr, input logic [9:0] ba);
    int t;
    send_cmd(wr, ba, 0, t);
    check_eq("len0_done", bus.done, 1);
    check_eq("len0_rd_valid", bus.rd_valid, 0);
    check_eq("len0_wr_ready", bus.wr_ready, 0);
    check_eq("len0_wr_en", bus.dmem_byte_wr_en, 0);
    finish_pulse();
  endtask

  initial begin
    int t, nd, nbad;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_byte_addr = 0; bus.cmd_len = 0;
    bus.wr_valid = 0; bus.wr_data = 0; bus.wr_strb = 0; bus.rd_ready = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();

    // Whole memory, wrapping from word 64 back round to 63.
    run_write(10'h100, Size, 1'b0, 32'h0, 1'b1, 4'hF, 1'b0);
    run_read(10'h100, Size, 1);

    run_write(10'h010, 4, 1'b1, 32'hA0, 1'b0, 4'hF, 1'b0);
    run_read(10'h010, 4, 0);
    run_read(10'h020, 8, 2);

    run_write(10'h3F8, 4, 1'b1, 32'h0, 1'b1, 4'hF, 1'b0);
    run_read(10'h3F8, 4, 0);

    run_write(10'h050, 1, 1'b1, 32'h11223344, 1'b0, 4'hF, 1'b0);
    run_write(10'h050, 1, 1'b1, 32'h0000AB00, 1'b0, 4'b0010, 1'b0);
    run_read(10'h050, 1, 0);
    check_eq("partial_strobe", mem[20], 32'h1122AB44);

    run_len0(1'b1, 10'h0C4);
    run_len0(1'b0, 10'h0C8);

    // Reset after two of four words: word 1 is driven as reset is sampled, word 2 never.
    send_cmd(1'b1, 10'h040, 4, t);
    for (int k = 0; k < 2; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hC0DE0000 + 32'(k);
      bus.wr_strb  = 4'hF;
      exp_wq.push_back({8'(16 + k), 2'b00, bus.wr_data, 4'hF});
      ref_mem[16 + k] = bus.wr_data;
      tick();
    end
    nd = n_done;
    reset_n      = 1'b0;
    bus.wr_data  = 32'hDEADBEEF;
    tick();
    check_reset_vals();
    reset_n      = 1'b1;
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    check_eq("rst_no_done", n_done, nd);
    check_eq("rst_pending_writes", exp_wq.size(), 0);
    check_eq("rst_word2_kept", mem[18], ref_mem[18]);
    check_eq("rst_word3_kept", mem[19], ref_mem[19]);

    for (int i = 0; i < 16; i++) begin
      logic [9:0] ba;
      int len;
      bit wr;
      wr  = 1'($urandom_range(0, 1));
      ba  = 10'($urandom_range(0, 1023));
      len = $urandom_range(0, 24);
      if (len == 0)  run_len0(wr, ba);
      else if (wr)   run_write(ba, len, 1'($urandom_range(0, 1)), 32'h0, 1'b1, 4'hF, 1'b1);
      else           run_read(ba, len, $urandom_range(0, 2));
    end

    nbad = 0;
    for (int i = 0; i < Size; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check_eq("final_mem_words_wrong", nbad, 0);
    check_eq("final_write_queue", exp_wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
